// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared float16 field layout, constants and converter FSM states
package fp16_pkg;

    localparam int FP16_EXP_W      = 5;
    localparam int FP16_MANT_W     = 10;
    localparam int FP16_BIAS       = 15;
    localparam int FP16_RSHIFT_CAP = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN,
        DONE
    } fsm_state_t;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_MANT_W-1:0] mant;
    } fp16_t;

endpackage

// File: rtl/fp16_fix_sat.sv
// rtl/fp16_fix_sat.sv - combinational round, saturate and negate stage for the fixed-point result
module fp16_fix_sat #(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0] mag,
    input  logic             g,
    input  logic             ovf,
    input  logic             s,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    logic [OUT_W:0] mag_r;
    logic [OUT_W:0] lim;

    always_comb begin
        // One extra bit so rounding an all-ones magnitude still trips the limit
        mag_r = {1'b0, mag} + {{OUT_W{1'b0}}, g & ~ovf};
        lim   = {2'b00, {(OUT_W-1){1'b1}}} + {{OUT_W{1'b0}}, s};
        if (ovf || (mag_r > lim)) begin
            out_data = s ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            out_sat  = 1'b1;
        end else begin
            out_data = s ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
            out_sat  = 1'b0;
        end
    end

endmodule

// File: rtl/fp16_to_fix.sv
// rtl/fp16_to_fix.sv - bit-serial float16 to signed fixed-point converter; FP2FIX_ROUND_EN selects round-half-away
module fp16_to_fix
    import fp16_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             out_ready
);

    fsm_state_t state, state_n;

    fp16_t             op;
    logic signed [6:0] k;
    logic [6:0]        neg_k;
    logic [6:0]        n_load;
    logic              special;
    logic              accept;

    logic [6:0]        cnt;
    logic [OUT_W-1:0]  mag;
    logic              ovf;
    logic              sgn;
    logic              left;
    logic              g;

    logic [OUT_W-1:0]  sat_data;
    logic              sat_flag;

    assign op       = in_data;
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign special  = (op.exp == '0) || (op.exp == '1);

    always_comb begin
        k      = $signed({2'b00, op.exp} + 7'(FRAC_W) - 7'(FP16_BIAS + FP16_MANT_W));
        neg_k  = -k;
        n_load = 7'd0;
        if (k[6]) begin
            n_load = (neg_k > 7'(FP16_RSHIFT_CAP)) ? 7'(FP16_RSHIFT_CAP) : neg_k;
        end else begin
            n_load = k;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (special || n_load == 7'd0) ? FIN : SHIFT;
            SHIFT:   if ((left && mag[OUT_W-1]) || cnt == 7'd1) state_n = FIN;
            FIN:     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 7'd0;
            mag      <= '0;
            ovf      <= 1'b0;
            sgn      <= 1'b0;
            left     <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn  <= op.sign;
                        left <= ~k[6];
                        cnt  <= n_load;
                        // e==31 saturates via ovf; e==0 flushes by loading a zero magnitude
                        ovf  <= (op.exp == '1);
                        mag  <= (op.exp == '0) ? '0 : {{(OUT_W-11){1'b0}}, 1'b1, op.mant};
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 7'd1;
                    if (left) begin
                        if (mag[OUT_W-1]) ovf <= 1'b1;
                        else              mag <= mag << 1;
                    end else begin
                        mag <= mag >> 1;
                    end
                end
                FIN: begin
                    out_data <= sat_data;
                    out_sat  <= sat_flag;
                end
                default: ;
            endcase
        end
    end

`ifdef FP2FIX_ROUND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g <= 1'b0;
        end else if (state == IDLE && accept) begin
            g <= 1'b0;
        end else if (state == SHIFT && !left) begin
            g <= mag[0];
        end
    end
`else
    assign g = 1'b0;
`endif

    fp16_fix_sat #(
        .OUT_W (OUT_W)
    ) u_sat (
        .mag      (mag),
        .g        (g),
        .ovf      (ovf),
        .s        (sgn),
        .out_data (sat_data),
        .out_sat  (sat_flag)
    );

endmodule

// File: tb/tb_fp16_to_fix.sv
// tb/tb_fp16_to_fix.sv - scoreboard bench for fp16_to_fix (OUT_W=16, FRAC_W=8)
module tb_fp16_to_fix;

`ifdef FP2FIX_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
        logic        sat;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
        logic        sat;
        int          lat;
        int          t0;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_ready = 1'b1;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    sb_t  sbq[$];
    vec_t vecs[$];
    sb_t  mon_e;
    bit   seen = 1'b0;

    fp16_to_fix #(.OUT_W(16), .FRAC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious out_valid, queue size", sbq.size(), 1);
            end else begin
                mon_e = sbq[0];
                if (!seen) begin
                    chk($sformatf("latency[%h]", mon_e.din), cyc - mon_e.t0, mon_e.lat);
                    seen = 1'b1;
                end
                chk($sformatf("out_data[%h]", mon_e.din), out_data, mon_e.exp);
                chk($sformatf("out_sat[%h]", mon_e.din), out_sat, mon_e.sat);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int w;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = v.din;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (in_ready) sbq.push_back('{v.din, v.exp, v.sat, v.lat, cyc});
        else chk($sformatf("accept timeout[%h]", v.din), in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain, entries left", sbq.size(), 0);
    endtask

    initial begin
        vecs.push_back('{16'h3C00, 16'h0100, 1'b0, 4});
        vecs.push_back('{16'hC100, 16'hFD80, 1'b0, 3});
        vecs.push_back('{16'h5A40, 16'h7FFF, 1'b1, 7});
        vecs.push_back('{16'hDA40, 16'h8000, 1'b1, 7});
        vecs.push_back('{16'h7C00, 16'h7FFF, 1'b1, 2});
        vecs.push_back('{16'hFC00, 16'h8000, 1'b1, 2});
        vecs.push_back('{16'h1800, RND ? 16'h0001 : 16'h0000, 1'b0, 13});
        vecs.push_back('{16'h9800, RND ? 16'hFFFF : 16'h0000, 1'b0, 13});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 2});
        vecs.push_back('{16'h8000, 16'h0000, 1'b0, 2});
        vecs.push_back('{16'h0200, 16'h0000, 1'b0, 2});
        vecs.push_back('{16'h0400, 16'h0000, 1'b0, 14});
        vecs.push_back('{16'h4400, 16'h0400, 1'b0, 2});
        vecs.push_back('{16'h5800, 16'h7FFF, 1'b1, 7});
        vecs.push_back('{16'hD800, 16'h8000, 1'b0, 7});
        vecs.push_back('{16'h57FF, 16'h7FF0, 1'b0, 6});
        vecs.push_back('{16'h7800, 16'h7FFF, 1'b1, 8});
        vecs.push_back('{16'h3E00, 16'h0180, 1'b0, 4});
        vecs.push_back('{16'h3C02, RND ? 16'h0101 : 16'h0100, 1'b0, 4});
        vecs.push_back('{16'hBC02, RND ? 16'hFEFF : 16'hFF00, 1'b0, 4});

        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_sat", out_sat, 0);
        chk("reset in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", in_ready, 1);

        foreach (vecs[i]) begin
            send(vecs[i]);
            drain();
        end

        // back-to-back operands with the result held off for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                send('{16'h3C00, 16'h0100, 1'b0, 4});
                send('{16'hC100, 16'hFD80, 1'b0, 3});
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                chk("held result out_valid", out_valid, 1);
                chk("busy in_ready", in_ready, 0);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of a 12-shift conversion
        send('{16'h0400, 16'h0000, 1'b0, 14});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("mid-op reset out_valid", out_valid, 0);
        chk("mid-op reset in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after reset in_ready", in_ready, 1);
        chk("after reset out_valid", out_valid, 0);
        chk("after reset out_data", out_data, 0);
        repeat (15) @(negedge clk);
        chk("discarded op out_valid", out_valid, 0);
        send('{16'h5A40, 16'h7FFF, 1'b1, 7});
        drain();
        send('{16'h3C00, 16'h0100, 1'b0, 4});
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp16_to_fix.md
# fp16_to_fix

Iterative converter from float16 (1-5-10, bias 15) to signed two's-complement fixed point. It sits at the output of the float16 filter datapath, after the float adders/MACs, and feeds the DAC/integer side. It is the reverse of the adder's normalizer: it denormalizes by shifting the significand one bit per clock, which keeps area small. Input and output use valid/ready handshakes. The block processes one conversion at a time.

## Interface
- `OUT_W`, default 16: output width (signed), legal range 12..32.
- `FRAC_W`, default 8: fractional bits of the output Q format, legal range 0..OUT_W-2.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: `in_data` is valid.
- `in_data  in  16`: float16 operand.
- `in_ready  out  1`: equals (state==IDLE) && !rst.
- `out_valid  out  1`: `out_data` / `out_sat` are valid. Reset value 0.
- `out_data  out  OUT_W`: converted value. Reset value 0.
- `out_sat  out  1`: result was clamped. Reset value 0.
- `out_ready  in  1`: downstream accepts the result.

## Operation
- Unpack the input: s = in_data[15], e = in_data[14:10], M = {1, in_data[9:0]} (11 bits). The value is (-1)^s × M × 2^(e-25).
- Compute the shift k = e - 25 + FRAC_W, as a signed 7-bit value.
- Special cases, both with n = 0 (no SHIFT cycles):
  - e==0 → result 0, out_sat=0. Subnormals and ±0 flush to zero.
  - e==31 → saturate by sign, out_sat=1.
- Shift count:
  - k<0: n = min(-k, 12), right shifts.
  - k>0: n = k, left shifts.
  - k=0: n = 0.
- Datapath: the magnitude register MAG is OUT_W bits wide and loads M, zero-extended. The guard register G loads 0.
  - Right shift: G ← MAG[0]; MAG ← MAG>>1.
  - Left shift: if MAG[OUT_W-1]==1, set sticky ovf and leave SHIFT immediately. Otherwise MAG ← MAG<<1.
- FIN, in order:
  - Apply rounding per Configuration.
  - Saturation limit L = 2^(OUT_W-1)-1 if s=0, 2^(OUT_W-1) if s=1.
  - If ovf or MAG > L: out_data = s ? 100..0 : 011..1 and out_sat=1.
  - Otherwise out_data = s ? -MAG : MAG and out_sat=0.
  - A result of magnitude 0 is always 0 (no -0).
- FSM states and transitions:
  - IDLE: on in_valid && in_ready, capture the operand; go to SHIFT if n>0, else FIN.
  - SHIFT: decrement the count each cycle; go to FIN when the count reaches 0 or ovf sets.
  - FIN: register out_data/out_sat; go to DONE.
  - DONE: out_valid=1; when out_ready=1, go to IDLE.
- Input not accepted while busy: in_ready=0 outside IDLE.

## Timing
- Accept edge T. SHIFT occupies cycles T+1..T+n. FIN occurs at T+n+1. out_valid rises at T+n+2.
- Latency is n+2 cycles, n ≤ max(12, OUT_W). A special case or k=0 gives latency 2.
- out_data/out_sat are stable while out_valid=1 && out_ready=0.
- Handshake at the DONE edge: out_valid falls the next cycle and in_ready is 1 that cycle. Minimum spacing is n+3 cycles.
- If out_ready is held high, the result is consumed in the first DONE cycle.
- Reset asserted mid-operation: the block immediately returns to IDLE. out_valid=0, out_data=0, out_sat=0. The operand in flight is discarded.

## Configuration
- `FP2FIX_ROUND_EN` defined: round half away from zero. In FIN, if G==1 and no ovf, MAG ← MAG+1, before the saturation check.
- `FP2FIX_ROUND_EN` undefined: truncate the magnitude (round toward zero). G is not implemented.
- Latency is identical in both modes.

## Structure
- Package `fp16_pkg` holds:
  - `FP16_EXP_W=5`, `FP16_MANT_W=10`, `FP16_BIAS=15`, `FP16_RSHIFT_CAP=12`.
  - The FSM state enum (IDLE, SHIFT, FIN, DONE).
  - The fp16 field-unpack typedef.
- One sub-module, `fp16_fix_sat`: a combinational round, saturate and negate stage used in FIN. Inputs MAG, G, ovf, s; outputs out_data, out_sat.

## Test plan
Parameters for all cases: OUT_W=16, FRAC_W=8.

- 0x3C00 (1.0) → out_data=0x0100, out_sat=0. out_valid 4 cycles after accept (n=2).
- 0xC100 (-2.5) → 0xFD80, out_sat=0. Latency 3.
- 0x5A40 (200.0) → 0x7FFF, out_sat=1. 0xDA40 → 0x8000, out_sat=1. 0x7C00 → 0x7FFF, out_sat=1, latency 2.
- 0x1800 (2^-9):
  - With `FP2FIX_ROUND_EN` → 0x0001.
  - Without → 0x0000.
  - 0x9800 gives 0xFFFF with rounding and 0x0000 without.
- 0x0000, 0x8000, 0x0200 (subnormal) → 0x0000, latency 2. 0x0400 → 0x0000 after 12 SHIFT cycles.
- Handshake and reset:
  - Back-to-back in_valid: the second operand waits until in_ready; out_ready held low for 5 cycles → out_data stable.
  - rst pulse during SHIFT → out_valid=0, in_ready=1 after release, and the next conversion is correct.
